// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: issues credit-limited FIFO reads, tracks returns and buffers words for a valid/ready consumer.
// Optional statistics counters are built when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream #(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          fifoEmpty,
    input  logic [$clog2(FIFO_DEPTH):0]   fifoDataCount,
    input  logic [FIFO_WIDTH-1:0]         fifoRdData,
    output logic                          fifoRdEn,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [FIFO_WIDTH-1:0]         outData,
    output logic                          busy,
    output logic [31:0]                   beatCount,
    output logic [31:0]                   stallCount
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned IW = $clog2(RD_LATENCY) + 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + RD_LATENCY) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  clr_ptrs;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [OW-1:0]         occ;
    logic [IW-1:0]         inflight;
    logic [RD_LATENCY-1:0] ret_sr;
    logic [FIFO_WIDTH-1:0] mem [BUF_DEPTH];
    logic                  pop;
    logic                  accept;
    logic                  ret;
    logic                  wr;
    logic [CW-1:0]         credit_used;
    logic                  unused_count;

    // Occupancy is informational only on this side of the FIFO.
    assign unused_count = ^fifoDataCount;

    // Credits cover both buffered words and reads still in the FIFO pipeline.
    assign credit_used = CW'(occ) + CW'(inflight) - CW'(pop);
    assign fifoRdEn    = en && !fifoEmpty && (state != DRAIN) && (credit_used < CW'(BUF_DEPTH));
    assign accept      = fifoRdEn && !fifoEmpty;
    assign outValid    = (occ != '0) && (state != DRAIN);
    assign pop         = outValid && outReady;
    assign ret         = ret_sr[RD_LATENCY-1];
    assign wr          = ret && (state != DRAIN);
    assign outData     = mem[rd_ptr];
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_ptrs  = 1'b0;
        case (state)
            IDLE: begin
                clr_ptrs = flush;
                if (accept) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (flush) begin
                    state_nxt = DRAIN;
                end else if ((occ == '0) && (inflight == '0) && !accept) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_nxt = IDLE;
                    clr_ptrs  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Return tracking and circular buffer; returns landing during DRAIN are dropped.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            ret_sr   <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            ret_sr   <= RD_LATENCY'({ret_sr, accept});
            inflight <= inflight + IW'(accept) - IW'(ret);
            if (clr_ptrs) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (wr) begin
                    mem[wr_ptr] <= fifoRdData;
                    wr_ptr      <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                occ <= occ + OW'(wr) - OW'(pop);
            end
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Delivery and backpressure statistics; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            beatCount  <= '0;
            stallCount <= '0;
        end else begin
            if (pop) begin
                beatCount <= beatCount + 32'd1;
            end
            if (outValid && !outReady) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end
`else
    assign beatCount  = '0;
    assign stallCount = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO of fixed read latency.
module tb_fifo_rd_stream;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned RL = 2;
    localparam int unsigned BD = 4;
`ifdef FIFO_RD_STREAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk;
    logic         resetN;
    logic         en;
    logic         flush;
    logic         fifoEmpty;
    logic [3:0]   fifoDataCount;
    logic [W-1:0] fifoRdData;
    logic         fifoRdEn;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outData;
    logic         busy;
    logic [31:0]  beatCount;
    logic [31:0]  stallCount;

    int vecs = 0;
    int errs = 0;
    int acc_cnt = 0;
    logic [7:0] fq[$];
    logic [7:0] rxq[$];
    logic [7:0] pipe [RL];
    logic [7:0] t2w [8] = '{8'h00, 8'h81, 8'h42, 8'hC3, 8'h24, 8'hA5, 8'h66, 8'hE7};
    logic [7:0] t3w [6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};

    fifo_rd_stream #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D), .RD_LATENCY(RL), .BUF_DEPTH(BD)
    ) dut (
        .clk(clk), .resetN(resetN), .en(en), .flush(flush),
        .fifoEmpty(fifoEmpty), .fifoDataCount(fifoDataCount), .fifoRdData(fifoRdData),
        .fifoRdEn(fifoRdEn), .outValid(outValid), .outReady(outReady), .outData(outData),
        .busy(busy), .beatCount(beatCount), .stallCount(stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] st(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [31:0] rx(input int i);
        if (i < rxq.size()) return 32'(rxq[i]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fq.push_back(w);
        fifoEmpty     = 1'b0;
        fifoDataCount = 4'(fq.size());
    endtask

    // One clock: sample handshakes before the edge, then advance the FIFO model.
    task automatic tick();
        logic acc;
        #1;
        acc = fifoRdEn && !fifoEmpty;
        if (acc) acc_cnt++;
        if (outValid && outReady) rxq.push_back(outData);
        @(posedge clk);
        #1;
        for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]       = acc ? fq.pop_front() : 8'hEE;
        fifoRdData    = pipe[RL-1];
        fifoEmpty     = (fq.size() == 0);
        fifoDataCount = 4'(fq.size());
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic rden, input logic valid);
        check({tag, "_rden"}, 32'(fifoRdEn), 32'(rden));
        check({tag, "_valid"}, 32'(outValid), 32'(valid));
    endtask

    initial begin
        resetN = 1'b0; en = 1'b0; flush = 1'b0; outReady = 1'b0;
        fifoEmpty = 1'b1; fifoDataCount = 4'd0; fifoRdData = 8'hEE;
        for (int i = 0; i < int'(RL); i++) pipe[i] = 8'hEE;
        @(negedge clk);
        tick(); tick();
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_data", 32'(outData), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rden", 32'(fifoRdEn), 32'd0);
        check("rst_beat", beatCount, 32'd0);
        check("rst_stall", stallCount, 32'd0);
        resetN = 1'b1;
        tick();

        // Three words, consumer always ready
        push(8'h11); push(8'h22); push(8'h33);
        en = 1'b1; outReady = 1'b1;
        #1 cyc("t1_c0", 1'b1, 1'b0); tick();
        cyc("t1_c1", 1'b1, 1'b0); check("t1_busy", 32'(busy), 32'd1); tick();
        cyc("t1_c2", 1'b1, 1'b0); tick();
        cyc("t1_c3", 1'b0, 1'b1); check("t1_d0", 32'(outData), 32'h11); tick();
        cyc("t1_c4", 1'b0, 1'b1); check("t1_d1", 32'(outData), 32'h22); tick();
        cyc("t1_c5", 1'b0, 1'b1); check("t1_d2", 32'(outData), 32'h33); tick();
        cyc("t1_c6", 1'b0, 1'b0); tick(); tick();
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_beat", beatCount, st(3));
        check("t1_stall", stallCount, st(0));

        // Full FIFO against a stalled consumer: credits cap accepts at BUF_DEPTH
        rxq.delete(); acc_cnt = 0; outReady = 1'b0;
        for (int i = 0; i < 8; i++) push(t2w[i]);
        for (int i = 0; i < 8; i++) begin
            if (i >= 4) check("t2_rden_off", 32'(fifoRdEn), 32'd0);
            if (i >= 3) check("t2_hold", 32'(outData), 32'h00);
            tick();
        end
        check("t2_accepts", 32'(acc_cnt), 32'd4);
        check("t2_rden_end", 32'(fifoRdEn), 32'd0);
        check("t2_valid", 32'(outValid), 32'd1);
        check("t2_head", 32'(outData), 32'h00);
        check("t2_stall", stallCount, st(5));
        outReady = 1'b1;
        repeat (14) tick();
        check("t2_count", 32'(rxq.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("t2_word", rx(i), 32'(t2w[i]));
        check("t2_beat", beatCount, st(11));
        check("t2_idle", 32'(busy), 32'd0);

        // Consumer toggling ready every cycle
        rxq.delete();
        for (int i = 0; i < 6; i++) push(t3w[i]);
        for (int i = 0; i < 20; i++) begin
            outReady = (i % 2 == 0);
            tick();
        end
        outReady = 1'b1;
        tick();
        check("t3_count", 32'(rxq.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("t3_word", rx(i), 32'(t3w[i]));
        check("t3_stall", stallCount, st(11));
        check("t3_beat", beatCount, st(17));

        // Flush with one word buffered and two reads in flight
        rxq.delete(); outReady = 1'b0;
        push(8'h61);
        tick(); tick(); tick();
        check("t4_valid", 32'(outValid), 32'd1);
        check("t4_head", 32'(outData), 32'h61);
        push(8'h62); push(8'h63); push(8'h64); push(8'h65);
        tick(); tick();
        en = 1'b0; flush = 1'b1;
        #1 check("t4_fl_valid", 32'(outValid), 32'd1);
        check("t4_fl_rden", 32'(fifoRdEn), 32'd0);
        tick();
        flush = 1'b0;
        check("t4_drop", 32'(outValid), 32'd0);
        check("t4_busy0", 32'(busy), 32'd1);
        tick();
        check("t4_busy1", 32'(busy), 32'd1);
        check("t4_drain_valid", 32'(outValid), 32'd0);
        tick();
        check("t4_busy2", 32'(busy), 32'd0);
        en = 1'b1; outReady = 1'b1;
        repeat (8) tick();
        check("t4_count", 32'(rxq.size()), 32'd2);
        check("t4_next0", rx(0), 32'h64);
        check("t4_next1", rx(1), 32'h65);
        check("t4_beat", beatCount, st(19));
        check("t4_stall", stallCount, st(14));

        // en low with two words buffered: drain only
        rxq.delete(); outReady = 1'b0;
        push(8'h91); push(8'h92);
        repeat (4) tick();
        check("t5_head", 32'(outData), 32'h91);
        en = 1'b0;
        push(8'h93); push(8'h94);
        outReady = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("t5_rden", 32'(fifoRdEn), 32'd0);
            tick();
        end
        check("t5_count", 32'(rxq.size()), 32'd2);
        check("t5_w0", rx(0), 32'h91);
        check("t5_w1", rx(1), 32'h92);
        check("t5_stall", stallCount, st(15));
        check("t5_beat", beatCount, st(21));
        check("t5_idle", 32'(busy), 32'd0);

        // Reset with two reads in flight
        rxq.delete(); en = 1'b1;
        #1 check("t6_rden", 32'(fifoRdEn), 32'd1);
        tick(); tick();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        check("t6_valid", 32'(outValid), 32'd0);
        check("t6_data", 32'(outData), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_beat", beatCount, 32'd0);
        check("t6_stall", stallCount, 32'd0);
        check("t6_rden_empty", 32'(fifoRdEn), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_no_stale", 32'(outValid), 32'd0);
        end
        check("t6_rx_none", 32'(rxq.size()), 32'd0);
        push(8'hB1);
        repeat (6) tick();
        check("t6_count", 32'(rxq.size()), 32'd1);
        check("t6_word", rx(0), 32'hB1);
        check("t6_beat2", beatCount, st(1));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
